// File: rtl/spike_window_counter.sv
// Spike window counter: counts spikes from an upstream LIF neuron over a
// fixed window of enabled cycles. Each completed window's count goes into a
// small result FIFO that drains through a valid/ready handshake. A sticky
// flag records whether a result was dropped because the FIFO was full.
module spike_window_counter #(
    parameter int WINDOW = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spike,
    input  logic                     en,
    input  logic                     clear,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_count,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int              PW         = $clog2(DEPTH);
    localparam int              LW         = PW + 1;
    localparam logic [9:0]      WIN_LAST   = 10'(WINDOW - 1);
    localparam logic [LW-1:0]   LEVEL_FULL = LW'(DEPTH);

    logic [9:0]    win_cnt_q, win_cnt_d;
    logic [7:0]    spk_cnt_q, spk_cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    mem_q [DEPTH];

    logic          window_end;
    logic [8:0]    spk_sum;
    logic [7:0]    result;
    logic          fifo_empty;
    logic          fifo_full;
    logic          do_pop;
    logic          want_push;
    logic          do_push;

    // Window-end detection, saturating spike sum and FIFO handshake decisions.
    // NOTE: combinational blocks use blocking assignments and give every
    // output a value first, so no latch can be inferred on any path.
    always_comb begin
        window_end = en && (win_cnt_q == WIN_LAST);
        spk_sum    = {1'b0, spk_cnt_q} + {8'd0, spike};
        result     = spk_sum[8] ? 8'hFF : spk_sum[7:0];
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LEVEL_FULL);
        // clear wins over everything, including the handshake.
        do_pop     = !clear && !fifo_empty && out_ready;
        want_push  = !clear && window_end;
        // A full FIFO still accepts a push when a pop frees a slot the same edge.
        do_push    = want_push && (!fifo_full || do_pop);
    end

    // Next state of the window and spike counters; the spike on the window-end
    // cycle is already folded into result, so it belongs to the closing window.
    always_comb begin
        win_cnt_d = win_cnt_q;
        spk_cnt_d = spk_cnt_q;
        if (clear) begin
            win_cnt_d = '0;
            spk_cnt_d = '0;
        end else if (en) begin
            if (win_cnt_q == WIN_LAST) begin
                win_cnt_d = '0;
                spk_cnt_d = '0;
            end else begin
                win_cnt_d = win_cnt_q + 10'd1;
                spk_cnt_d = result;
            end
        end
    end

    // Next state of FIFO pointers, occupancy and the sticky drop flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH.
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            level_d = level_q + LW'(do_push) - LW'(do_pop);
            if (want_push && !do_push) overflow_d = 1'b1;
        end
    end

    // Control state register with asynchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q  <= '0;
            spk_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            win_cnt_q  <= win_cnt_d;
            spk_cnt_q  <= spk_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Result storage write port.
    // NOTE: the storage array is deliberately not reset; occupancy is reset,
    // and out_count is forced to zero while empty, so stale entries never show.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= result;
    end

    assign out_valid = !fifo_empty;
    assign out_count = fifo_empty ? 8'd0 : mem_q[rd_ptr_q];
    assign level     = level_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_spike_window_counter.sv
// Self-checking bench for spike_window_counter. A reference model predicts
// each window result from plain counting and keeps the expected FIFO contents
// in a queue; monitors pop that queue on every output handshake and compare.
module tb_spike_window_counter;

    localparam int W     = 16;
    localparam int D     = 4;
    localparam int SAT_W = 300;

    logic       clk;
    logic       rst_n;
    logic       spike, en, clear, out_ready;
    logic       out_valid;
    logic [7:0] out_count;
    logic [2:0] level;
    logic       overflow;

    logic       s_spike, s_en, s_clear, s_ready;
    logic       s_valid;
    logic [7:0] s_count;
    logic [1:0] s_level;
    logic       s_ovf;

    int checks = 0;
    int errors = 0;

    // Reference model state (main instance)
    int mdl_pos   = 0;
    int mdl_spk   = 0;
    int mdl_level = 0;
    bit mdl_ovf   = 0;
    int exp_q[$];

    // Reference model state (saturation instance)
    int sat_q[$];
    int sat_seen = 0;

    spike_window_counter #(.WINDOW(W), .DEPTH(D)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spike     (spike),
        .en        (en),
        .clear     (clear),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_count (out_count),
        .level     (level),
        .overflow  (overflow)
    );

    spike_window_counter #(.WINDOW(SAT_W), .DEPTH(2)) u_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .spike     (s_spike),
        .en        (s_en),
        .clear     (s_clear),
        .out_ready (s_ready),
        .out_valid (s_valid),
        .out_count (s_count),
        .level     (s_level),
        .overflow  (s_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_flush();
        mdl_pos   = 0;
        mdl_spk   = 0;
        mdl_level = 0;
        mdl_ovf   = 0;
        exp_q.delete();
    endtask

    // What the next rising edge does, in terms of window/FIFO behaviour.
    task automatic model_edge(input logic s, input logic e, input logic c, input logic r);
        bit pop;
        bit push;
        int val;
        if (c) begin
            model_flush();
            return;
        end
        pop  = (mdl_level > 0) && r;
        push = 0;
        val  = 0;
        if (e) begin
            mdl_spk += int'(s);
            mdl_pos++;
            if (mdl_pos == W) begin
                push    = 1;
                val     = (mdl_spk > 255) ? 255 : mdl_spk;
                mdl_pos = 0;
                mdl_spk = 0;
            end
        end
        if (push) begin
            if (mdl_level < D || pop) begin
                exp_q.push_back(val);
                mdl_level++;
            end else begin
                mdl_ovf = 1;
            end
        end
        if (pop) mdl_level--;
    endtask

    task automatic check_state();
        check("out_valid", int'(out_valid), int'(mdl_level != 0));
        check("level", int'(level), mdl_level);
        check("overflow", int'(overflow), int'(mdl_ovf));
        if (mdl_level == 0) check("count_when_empty", int'(out_count), 0);
    endtask

    // One clock cycle of stimulus; called at posedge+1.
    task automatic step(input logic s, input logic e, input logic c, input logic r);
        spike     = s;
        en        = e;
        clear     = c;
        out_ready = r;
        model_edge(s, e, c, r);
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic run_window(input logic [15:0] sp, input logic [15:0] rdy);
        for (int i = 0; i < W; i++) step(sp[i], 1'b1, 1'b0, rdy[i]);
    endtask

    task automatic pulse_reset();
        spike     = 1'b0;
        en        = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        model_flush();
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_count", int'(out_count), 0);
        check("rst_level", int'(level), 0);
        check("rst_overflow", int'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state();
    endtask

    // Output monitor (main instance): a pop happens at the coming edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !clear) begin
            if (exp_q.size() == 0) check("unexpected_result", int'(out_count), -1);
            else check("out_count", int'(out_count), exp_q.pop_front());
        end
    end

    // Output monitor (saturation instance).
    always @(negedge clk) begin
        if (rst_n && s_valid && s_ready) begin
            sat_seen++;
            if (sat_q.size() == 0) check("sat_unexpected", int'(s_count), -1);
            else check("sat_count", int'(s_count), sat_q.pop_front());
        end
    end

    initial begin
        int sat_pos;
        int sat_spk;
        rst_n     = 1'b0;
        spike     = 1'b0;
        en        = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        s_spike   = 1'b0;
        s_en      = 1'b0;
        s_clear   = 1'b0;
        s_ready   = 1'b0;
        #12;
        check_state();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state();

        // Saturation: 300-cycle windows with continuous spikes.
        sat_pos = 0;
        sat_spk = 0;
        for (int i = 0; i < 2 * SAT_W + 3; i++) begin
            s_en    = 1'b1;
            s_spike = 1'b1;
            s_ready = 1'b1;
            sat_pos++;
            sat_spk++;
            if (sat_pos == SAT_W) begin
                sat_q.push_back(sat_spk > 255 ? 255 : sat_spk);
                sat_pos = 0;
                sat_spk = 0;
            end
            @(posedge clk);
            #1;
        end
        s_en    = 1'b0;
        s_spike = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("sat_results_seen", sat_seen, 2);
        check("sat_queue_drained", sat_q.size(), 0);

        // Full window of spikes, downstream always ready.
        run_window(16'hFFFF, 16'hFFFF);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Every 4th cycle from cycle 3; spike only on window end; empty window.
        run_window(16'h8888, 16'hFFFF);
        run_window(16'h8000, 16'hFFFF);
        run_window(16'h0000, 16'hFFFF);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Five windows into a 4-deep FIFO with no drain: last result dropped.
        for (int n = 2; n <= 6; n++) run_window(16'((1 << n) - 1), 16'h0000);
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Full FIFO, ready only on the window-end cycle: push accepted.
        for (int n = 1; n <= 4; n++) run_window(16'((1 << n) - 1), 16'h0000);
        run_window(16'h0F0F, 16'h8000);
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Overflow, drain to level 2, then asynchronous reset mid-window.
        for (int n = 3; n <= 7; n++) run_window(16'((1 << n) - 1), 16'h0000);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (7) step(1'b1, 1'b1, 1'b0, 1'b0);
        pulse_reset();
        // Enable pause: spikes ignored, completion delayed by the pause.
        repeat (10) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
        run_window(16'hFFFF, 16'hFFFF);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 6));
        end

        // Drain everything still queued.
        repeat (D + 2) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
